// File: rtl/fc_mac_neuron.sv
// Time-multiplexed fully-connected neuron: one signed x*w product per beat,
// accumulated over IN beats, optional ReLU, result on a valid/ready output.
module fc_mac_neuron #(
    parameter int WIDTH = 8,
    parameter int IN = 128,
    parameter int RELU = 1,
    localparam int OUT_WIDTH = 2 * WIDTH + $clog2(IN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_w,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_z
);

    localparam int CW = $clog2(IN);
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(IN - 1);

    typedef enum logic [1:0] {ACC, DRAIN1, DRAIN2, OUT} state_t;

    state_t              state;
    state_t              state_next;
    logic [CW-1:0]       cnt;
    logic [PW-1:0]       prod;
    logic                prod_v;
    logic                prod_first;
    logic [OUT_WIDTH-1:0] acc;
    logic                accept;
    logic [PW-1:0]       x_ext;
    logic [PW-1:0]       w_ext;
    logic [OUT_WIDTH-1:0] prod_ext;

    assign accept   = in_valid && (state == ACC);
    assign x_ext    = {{WIDTH{in_x[WIDTH-1]}}, in_x};
    assign w_ext    = {{WIDTH{in_w[WIDTH-1]}}, in_w};
    assign prod_ext = {{(OUT_WIDTH - PW){prod[PW-1]}}, prod};

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (accept && (cnt == LAST)) state_next = DRAIN1;
            end
            DRAIN1: state_next = DRAIN2;
            DRAIN2: state_next = OUT;
            OUT: if (out_ready) state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACC;
            cnt        <= '0;
            prod       <= '0;
            prod_v     <= 1'b0;
            prod_first <= 1'b0;
            acc        <= '0;
            out_z      <= '0;
            out_valid  <= 1'b0;
        end else begin
            state  <= state_next;
            prod_v <= accept;
            if (accept) begin
                prod       <= x_ext * w_ext;
                prod_first <= (cnt == '0);
                cnt        <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
            // The first-element flag restarts the sum, so no clear cycle is needed.
            if (prod_v) acc <= (prod_first ? '0 : acc) + prod_ext;
            if (state == DRAIN2) begin
                out_z     <= ((RELU != 0) && acc[OUT_WIDTH-1]) ? '0 : acc;
                out_valid <= 1'b1;
            end else if ((state == OUT) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fc_mac_neuron.sv
// Self-checking bench for fc_mac_neuron: table vectors plus multi-cycle corner sequences.
module tb_fc_mac_neuron;

    localparam int OW4 = 18;
    localparam int OW128 = 23;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, out_ready;
    logic [7:0] in_x, in_w;
    logic in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [OW4-1:0] out_z_a, out_z_b;
    logic in_valid_c, out_ready_c;
    logic [7:0] in_x_c, in_w_c;
    logic in_ready_c, out_valid_c;
    logic [OW128-1:0] out_z_c;

    always #5 clk = ~clk;

    fc_mac_neuron #(.WIDTH(8), .IN(4), .RELU(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_x(in_x), .in_w(in_w), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_z(out_z_a));

    fc_mac_neuron #(.WIDTH(8), .IN(4), .RELU(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_x(in_x), .in_w(in_w), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_z(out_z_b));

    fc_mac_neuron #(.WIDTH(8), .IN(128), .RELU(0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .in_x(in_x_c), .in_w(in_w_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
        .out_z(out_z_c));

    typedef struct {
        logic [3:0][7:0] x;
        logic [3:0][7:0] w;
        longint er1;
        longint er0;
    } vec_t;

    vec_t tbl[6];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    longint q_a[$];
    longint q_b[$];
    longint q_c[$];
    int rise_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input int x0, x1, x2, x3, w0, w1, w2, w3, input longint r1, r0);
        vec_t v;
        v.x[0] = x0[7:0]; v.x[1] = x1[7:0]; v.x[2] = x2[7:0]; v.x[3] = x3[7:0];
        v.w[0] = w0[7:0]; v.w[1] = w1[7:0]; v.w[2] = w2[7:0]; v.w[3] = w3[7:0];
        v.er1 = r1;
        v.er0 = r0;
        return v;
    endfunction

    function automatic longint dot(input logic [3:0][7:0] x, input logic [3:0][7:0] w);
        longint s = 0;
        for (int i = 0; i < 4; i++) s += longint'($signed(x[i])) * longint'($signed(w[i]));
        return s;
    endfunction

    // Scoreboard monitors: sample on the falling edge, pop on each handshake.
    logic [OW4-1:0] prev_z_a;
    bit hold_a = 0;
    bit prev_v_a = 0;
    always @(negedge clk) begin
        if (rst) begin
            hold_a = 0;
            prev_v_a = 0;
        end else begin
            if (hold_a) begin
                check("hold_valid_a", longint'(out_valid_a), 1);
                check("hold_z_a", longint'(out_z_a), longint'(prev_z_a));
            end
            if (out_valid_a) begin
                check("busy_in_ready_a", longint'(in_ready_a), 0);
                if (!prev_v_a) rise_q.push_back(cyc);
                if (out_ready) begin
                    if (q_a.size() == 0) check("unexpected_out_a", longint'(out_valid_a), 0);
                    else check("out_z_a", longint'($signed(out_z_a)), q_a.pop_front());
                end
            end
            hold_a = out_valid_a && !out_ready;
            prev_z_a = out_z_a;
            prev_v_a = out_valid_a;
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid_b && out_ready) begin
            if (q_b.size() == 0) check("unexpected_out_b", longint'(out_valid_b), 0);
            else check("out_z_b", longint'($signed(out_z_b)), q_b.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid_c && out_ready_c) begin
            if (q_c.size() == 0) check("unexpected_out_c", longint'(out_valid_c), 0);
            else check("out_z_c", longint'($signed(out_z_c)), q_c.pop_front());
        end
    end

    task automatic beat(input logic [7:0] x, input logic [7:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_x = x;
        in_w = w;
        while (!in_ready_a && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("in_ready_timeout", longint'(in_ready_a), 1);
        else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic beat_c(input logic [7:0] x, input logic [7:0] w);
        int n = 0;
        in_valid_c = 1'b1;
        in_x_c = x;
        in_w_c = w;
        while (!in_ready_c && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("in_ready_c_timeout", longint'(in_ready_c), 1);
        else begin
            @(posedge clk); #1;
        end
        in_valid_c = 1'b0;
    endtask

    task automatic send_vec(input logic [3:0][7:0] x, input logic [3:0][7:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            beat(x[i], w[i]);
        end
    endtask

    task automatic wait_drained();
        int n = 0;
        while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) check("drain_timeout", longint'(q_a.size() + q_b.size() + q_c.size()), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready_a"}, longint'(in_ready_a), 1);
        check({tag, "_out_valid_a"}, longint'(out_valid_a), 0);
        check({tag, "_out_z_a"}, longint'(out_z_a), 0);
        check({tag, "_in_ready_b"}, longint'(in_ready_b), 1);
        check({tag, "_out_valid_b"}, longint'(out_valid_b), 0);
        check({tag, "_out_z_b"}, longint'(out_z_b), 0);
    endtask

    initial begin
        vec_t rv;
        int n;
        tbl[0] = mk(1, 2, 3, 4, 1, 1, 1, 1, 10, 10);
        tbl[1] = mk(1, 2, 3, 4, -1, -1, -1, -1, 0, -10);
        tbl[2] = mk(-3, 7, 0, 127, 5, -2, 100, -128, 0, -16285);
        tbl[3] = mk(-128, -128, -128, -128, -128, -128, -128, -128, 65536, 65536);
        tbl[4] = mk(127, 127, 127, 127, -128, -128, -128, -128, 0, -65024);
        tbl[5] = mk(5, -5, 3, -3, 2, 2, 2, 2, 0, 0);

        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_w = '0; out_ready = 1'b1;
        in_valid_c = 1'b0; in_x_c = '0; in_w_c = '0; out_ready_c = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state("reset");
        check("reset_in_ready_c", longint'(in_ready_c), 1);
        check("reset_out_valid_c", longint'(out_valid_c), 0);

        // T1: latency of two edges after the last accept
        q_a.push_back(tbl[0].er1);
        q_b.push_back(tbl[0].er0);
        send_vec(tbl[0].x, tbl[0].w, 1'b0);
        check("lat_e0_valid", longint'(out_valid_a), 0);
        check("lat_e0_ready", longint'(in_ready_a), 0);
        @(posedge clk); #1;
        check("lat_e1_valid", longint'(out_valid_a), 0);
        check("lat_e1_ready", longint'(in_ready_a), 0);
        @(posedge clk); #1;
        check("lat_e2_valid", longint'(out_valid_a), 1);
        wait_drained();

        // T2 and table vectors with random input gaps
        for (int i = 1; i < 6; i++) begin
            q_a.push_back(tbl[i].er1);
            q_b.push_back(tbl[i].er0);
            send_vec(tbl[i].x, tbl[i].w, 1'b1);
        end
        wait_drained();

        // T4: random vector, downstream stalled for 5 cycles
        for (int i = 0; i < 4; i++) begin
            rv.x[i] = 8'($urandom_range(0, 255));
            rv.w[i] = 8'($urandom_range(0, 255));
        end
        rv.er0 = dot(rv.x, rv.w);
        rv.er1 = (rv.er0 < 0) ? 0 : rv.er0;
        out_ready = 1'b0;
        q_a.push_back(rv.er1);
        q_b.push_back(rv.er0);
        send_vec(rv.x, rv.w, 1'b1);
        n = 0;
        while (!out_valid_a && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall_out_valid", longint'(out_valid_a), 1);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        q_a.push_back(tbl[0].er1);
        q_b.push_back(tbl[0].er0);
        send_vec(tbl[0].x, tbl[0].w, 1'b0);
        wait_drained();

        // T5: reset mid-vector discards the partial sum
        beat(8'd9, 8'd9);
        beat(8'd9, 8'd9);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_state("midrst");
        q_a.push_back(40);
        q_b.push_back(40);
        for (int i = 0; i < 4; i++) beat(8'd5, 8'd2);
        wait_drained();

        // T6: back-to-back vectors, period IN+3
        rise_q.delete();
        q_a.push_back(tbl[0].er1);
        q_b.push_back(tbl[0].er0);
        q_a.push_back(tbl[2].er1);
        q_b.push_back(tbl[2].er0);
        send_vec(tbl[0].x, tbl[0].w, 1'b0);
        send_vec(tbl[2].x, tbl[2].w, 1'b0);
        wait_drained();
        check("b2b_rises", longint'(rise_q.size()), 2);
        if (rise_q.size() == 2) check("b2b_period", longint'(rise_q[1] - rise_q[0]), 7);

        // T3: IN=128 extremes, no wrap
        q_c.push_back(2097152);
        for (int i = 0; i < 128; i++) beat_c(8'h80, 8'h80);
        q_c.push_back(-2080768);
        for (int i = 0; i < 128; i++) beat_c(8'h80, 8'h7F);
        wait_drained();

        check("queues_empty", longint'(q_a.size() + q_b.size() + q_c.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
